// File: rtl/tcp_segment_buffer.sv
// tcp_segment_buffer
//   Captures the 32-bit words of one TCP segment from the encoder, then
//   writes the final checksum into header word 4 bits [31:16]. After that
//   it streams the finished segment out on a valid/ready interface.
//   data[31:24] is the first byte on the wire.
//
// Optional feature: define TCP_SEG_BUF_STATS_EN to add the stat_sent and
//   stat_drop counters. Both counters saturate.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   in_data      segment word from the encoder
//   in_wr_en     in_data is valid this cycle
//   in_fin       last-word marker; in_checksum and in_len are valid this cycle
//   in_checksum  final TCP checksum
//   in_len       segment length in bytes
//   out_data     output word
//   out_valid    out_data is valid
//   out_ready    the consumer accepts the word
//   out_last     high on the final word of the segment
//   out_keep     byte enables, [3] = byte at [31:24]
//   out_len      latched segment length
//   busy         high in PATCH/SEND; writes are refused
//   err          one-cycle pulse: segment or write discarded
//   stat_sent    (optional) number of segments fully sent
//   stat_drop    (optional) number of err pulses
module tcp_segment_buffer #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter int unsigned ADDR_W      = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_wr_en,
    input  logic        in_fin,
    input  logic [15:0] in_checksum,
    input  logic [15:0] in_len,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [3:0]  out_keep,
    output logic [15:0] out_len,
    output logic        busy,
    output logic        err
`ifdef TCP_SEG_BUF_STATS_EN
    ,
    output logic [15:0] stat_sent,
    output logic [15:0] stat_drop
`endif
);

    // Word counters need one extra bit so that they can reach DEPTH_WORDS itself.
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned NW_W  = 15;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CHK_WORD  = CNT_W'(4);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_PATCH = 2'd1,
        S_SEND  = 2'd2
    } state_t;

    // Byte enables for the final word, taken from the length remainder.
    function automatic logic [3:0] last_keep(input logic [1:0] tail);
        case (tail)
            2'd1:    last_keep = 4'b1000;
            2'd2:    last_keep = 4'b1100;
            2'd3:    last_keep = 4'b1110;
            default: last_keep = 4'b1111;
        endcase
    endfunction

    logic [31:0] mem [DEPTH_WORDS];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wptr_q, wptr_d;
    logic [CNT_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   last_idx_q, last_idx_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        chk_q, chk_d;
    logic [15:0]        w4_lo_q, w4_lo_d;
    logic [15:0]        len_d;
    logic [31:0]        out_data_d;
    logic               out_valid_d, out_last_d;
    logic [3:0]         out_keep_d;
    logic [31:0]        pf_data_q, pf_data_d;
    logic               pf_valid_q, pf_valid_d;
    logic               pf_last_q, pf_last_d;
    logic [3:0]         pf_keep_q, pf_keep_d;
    logic               busy_d, err_d;

    logic               mem_we_c;
    logic [ADDR_W-1:0]  mem_waddr_c;
    logic [31:0]        mem_wdata_c;
    logic [31:0]        mem_rdata_c;
    logic [CNT_W-1:0]   wcnt_c;
    logic               ovf_c;
    logic [NW_W-1:0]    nwords_c;
    logic               seg_ok_c;
    logic               accept_c;
    logic               more_c;
    logic               rd_last_c;
    logic [3:0]         rd_keep_c;

    // Segment storage; the write port is shared by FILL and the checksum patch.
    always_ff @(posedge clk) begin
        if (reset && mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    assign mem_rdata_c = mem[rptr_q[ADDR_W-1:0]];

    // Next-state and datapath decisions for every register.
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        last_idx_d  = last_idx_q;
        ovf_d       = ovf_q;
        chk_d       = chk_q;
        w4_lo_d     = w4_lo_q;
        len_d       = out_len;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        out_keep_d  = out_keep;
        pf_data_d   = pf_data_q;
        pf_valid_d  = pf_valid_q;
        pf_last_d   = pf_last_q;
        pf_keep_d   = pf_keep_q;
        busy_d      = busy;
        err_d       = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = '0;
        mem_wdata_c = '0;
        wcnt_c      = wptr_q;
        ovf_c       = ovf_q;
        nwords_c    = '0;
        seg_ok_c    = 1'b0;
        accept_c    = 1'b0;
        more_c      = 1'b0;
        rd_last_c   = 1'b0;
        rd_keep_c   = 4'b1111;

        case (state_q)
            S_FILL: begin
                if (in_wr_en) begin
                    if (wptr_q < DEPTH_CNT) begin
                        mem_we_c    = 1'b1;
                        mem_waddr_c = wptr_q[ADDR_W-1:0];
                        mem_wdata_c = in_data;
                        wcnt_c      = wptr_q + CNT_W'(1);
                        // Keep the low half of word 4 so that the patch needs no read port.
                        if (wptr_q == CHK_WORD) begin
                            w4_lo_d = in_data[15:0];
                        end
                    end else begin
                        ovf_c = 1'b1;
                    end
                end
                wptr_d = wcnt_c;
                ovf_d  = ovf_c;
                // A word written in the same cycle as fin is already in wcnt_c.
                if (in_fin) begin
                    nwords_c = NW_W'((17'(in_len) + 17'd3) >> 2);
                    seg_ok_c = !ovf_c && (32'(nwords_c) == 32'(wcnt_c)) && (in_len >= 16'd20);
                    if (seg_ok_c) begin
                        state_d    = S_PATCH;
                        busy_d     = 1'b1;
                        chk_d      = in_checksum;
                        len_d      = in_len;
                        last_idx_d = wcnt_c - CNT_W'(1);
                    end else begin
                        err_d  = 1'b1;
                        wptr_d = '0;
                        ovf_d  = 1'b0;
                    end
                end
            end

            S_PATCH: begin
                err_d       = in_wr_en | in_fin;
                mem_we_c    = 1'b1;
                mem_waddr_c = ADDR_W'(4);
                mem_wdata_c = {chk_q, w4_lo_q};
                rptr_d      = '0;
                state_d     = S_SEND;
            end

            S_SEND: begin
                err_d     = in_wr_en | in_fin;
                accept_c  = out_valid && out_ready;
                more_c    = rptr_q <= last_idx_q;
                rd_last_c = rptr_q == last_idx_q;
                rd_keep_c = rd_last_c ? last_keep(out_len[1:0]) : 4'b1111;
                if (!out_valid || accept_c) begin
                    // The output slot is free: take the prefetched word first, then refill the prefetch.
                    if (pf_valid_q) begin
                        out_data_d  = pf_data_q;
                        out_last_d  = pf_last_q;
                        out_keep_d  = pf_keep_q;
                        out_valid_d = 1'b1;
                        if (more_c) begin
                            pf_data_d = mem_rdata_c;
                            pf_last_d = rd_last_c;
                            pf_keep_d = rd_keep_c;
                            rptr_d    = rptr_q + CNT_W'(1);
                        end else begin
                            pf_valid_d = 1'b0;
                        end
                    end else if (more_c) begin
                        out_data_d  = mem_rdata_c;
                        out_last_d  = rd_last_c;
                        out_keep_d  = rd_keep_c;
                        out_valid_d = 1'b1;
                        rptr_d      = rptr_q + CNT_W'(1);
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end else if (!pf_valid_q && more_c) begin
                    // Stalled: read ahead so that the word after the stall follows with no gap.
                    pf_data_d  = mem_rdata_c;
                    pf_last_d  = rd_last_c;
                    pf_keep_d  = rd_keep_c;
                    pf_valid_d = 1'b1;
                    rptr_d     = rptr_q + CNT_W'(1);
                end
                if (accept_c && out_last) begin
                    state_d     = S_FILL;
                    wptr_d      = '0;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    pf_valid_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_FILL;
            wptr_q     <= '0;
            rptr_q     <= '0;
            last_idx_q <= '0;
            ovf_q      <= 1'b0;
            chk_q      <= '0;
            w4_lo_q    <= '0;
            out_len    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_keep   <= '0;
            pf_data_q  <= '0;
            pf_valid_q <= 1'b0;
            pf_last_q  <= 1'b0;
            pf_keep_q  <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            last_idx_q <= last_idx_d;
            ovf_q      <= ovf_d;
            chk_q      <= chk_d;
            w4_lo_q    <= w4_lo_d;
            out_len    <= len_d;
            out_data   <= out_data_d;
            out_valid  <= out_valid_d;
            out_last   <= out_last_d;
            out_keep   <= out_keep_d;
            pf_data_q  <= pf_data_d;
            pf_valid_q <= pf_valid_d;
            pf_last_q  <= pf_last_d;
            pf_keep_q  <= pf_keep_d;
            busy       <= busy_d;
            err        <= err_d;
        end
    end

`ifdef TCP_SEG_BUF_STATS_EN
    logic seg_sent_c;

    assign seg_sent_c = (state_q == S_SEND) && out_valid && out_ready && out_last;

    // Saturating segment and drop counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_sent <= '0;
            stat_drop <= '0;
        end else begin
            if (seg_sent_c && (stat_sent != 16'hFFFF)) begin
                stat_sent <= stat_sent + 16'd1;
            end
            if (err_d && (stat_drop != 16'hFFFF)) begin
                stat_drop <= stat_drop + 16'd1;
            end
        end
    end
`endif

endmodule
